pll_lock_sequencer: RTL and testbench

Sequences reset and lock bring-up for the single-output video/core PLL (74.25 MHz ref -> 28.636363 MHz). It pulses the PLL reset, waits for lock with a timeout and bounded retries, and requires a lock-stable window before releasing the downstream core reset. It re-sequences on lock loss or on a restart request. Runs entirely on the PLL reference clock; consumers in the PLL output domain re-synchronize core_reset themselves.

---
 rtl/pll_lock_sequencer.sv | 152 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock bring-up sequencer, clocked by the PLL reference clock.
// Pulses pll_rst, waits for lock with timeout and bounded retries, requires a
// lock-stable window, then releases core_reset. Re-sequences on lock loss or
// on restart_req.
// Optional: define PLL_LOCK_SEQ_SYNC_EN to pass pll_locked through a 2-flop
// synchronizer before use (adds 2 cycles to every lock-driven transition).
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int STABLE_CYCLES       = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int RETRY_W             = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               restart_req,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               core_reset,
  output logic               ready,
  output logic               fail,
  output logic [2:0]         state,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                           RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  // cnt only has to reach MAX_CYC-1 before a transition clears it.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_s;
  logic               pll_rst_d, core_reset_d, ready_d, fail_d;

`ifdef PLL_LOCK_SEQ_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer bringing the raw lock pin into the refclk domain.
  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], pll_locked};
  end

  assign lock_s = sync_q[1];
`else
  assign lock_s = pll_locked;
`endif

  // Next-state, counter and retry logic; outputs decoded from the next state
  // so the registered outputs always match the state register.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);  // saturate, never wrap

    case (state_q)
      ST_RST_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == LOCK_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_RST_PLL;
          end
        end
      end
      ST_STABLE: begin
        // A glitch restarts the timeout window without a PLL reset or retry.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STAB_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) state_d = ST_RST_PLL;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RST_PLL;
      end
    endcase

    // A restart request overrides everything, including an RST_PLL pulse
    // already in progress.
    if (restart_req) begin
      state_d = ST_RST_PLL;
      retry_d = '0;
    end

    if (restart_req || (state_d != state_q)) cnt_d = '0;

    pll_rst_d    = (state_d == ST_RST_PLL);
    core_reset_d = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAIL);
  end

  // State, counter and registered output decode.
  always_ff @(posedge refclk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_RST_PLL;
      cnt_q      <= '0;
      retry_q    <= '0;
      pll_rst    <= 1'b1;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pll_rst    <= pll_rst_d;
      core_reset <= core_reset_d;
      ready      <= ready_d;
      fail       <= fail_d;
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed bring-up scenarios
// followed by randomized lock/restart/reset traffic, all outputs compared
// every cycle against a phase/elapsed-time reference model via a scoreboard.
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int LT = 20;
  localparam int ST = 8;
  localparam int MR = 2;
  localparam int RW = 2;
`ifdef PLL_LOCK_SEQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam int P_RST = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          restart_req = 1'b0;
  logic          pll_locked = 1'b0;
  logic          pll_rst, core_reset, ready, fail;
  logic [2:0]    state;
  logic [RW-1:0] retry_cnt;

  typedef struct packed {
    logic [2:0]    st;
    logic          pr;
    logic          cr;
    logic          rd;
    logic          fl;
    logic [RW-1:0] rc;
  } obs_t;

  obs_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // reference model state
  int m_phase = P_RST;
  int m_el    = 0;
  int m_fail  = 0;
  bit m_s1    = 1'b0;
  bit m_s2    = 1'b0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT_CYCLES(LT), .STABLE_CYCLES(ST),
    .MAX_RETRIES(MR), .RETRY_W(RW)
  ) dut (
    .refclk(refclk), .rst(rst), .restart_req(restart_req),
    .pll_locked(pll_locked), .pll_rst(pll_rst), .core_reset(core_reset),
    .ready(ready), .fail(fail), .state(state), .retry_cnt(retry_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Model: phase, cycles already spent in the phase, failed attempts so far.
  task automatic model_step(input bit r, input bit rr, input bit lk);
    bit ls;
`ifdef PLL_LOCK_SEQ_SYNC_EN
    ls = m_s2;
    if (r) begin m_s1 = 1'b0; m_s2 = 1'b0; end
    else   begin m_s2 = m_s1; m_s1 = lk;   end
`else
    ls = lk;
`endif
    if (r || rr) begin
      m_phase = P_RST; m_el = 0; m_fail = 0;
    end else begin
      case (m_phase)
        P_RST:
          if (m_el + 1 == RP) begin m_phase = P_WAIT; m_el = 0; end
          else m_el++;
        P_WAIT:
          if (ls) begin m_phase = P_STABLE; m_el = 0; end
          else if (m_el + 1 == LT) begin
            m_el = 0;
            if (m_fail == MR) m_phase = P_FAIL;
            else begin m_fail++; m_phase = P_RST; end
          end else m_el++;
        P_STABLE:
          if (!ls) begin m_phase = P_WAIT; m_el = 0; end
          else if (m_el + 1 == ST) begin m_phase = P_RUN; m_el = 0; m_fail = 0; end
          else m_el++;
        P_RUN:
          if (!ls) begin m_phase = P_RST; m_el = 0; end
        default: ;
      endcase
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    o.st = 3'(m_phase);
    o.pr = (m_phase == P_RST);
    o.cr = (m_phase != P_RUN);
    o.rd = (m_phase == P_RUN);
    o.fl = (m_phase == P_FAIL);
    o.rc = RW'(m_fail);
    return o;
  endfunction

  // Wait to the middle of the cycle; DUT outputs then show the current state.
  task automatic sample();
    @(negedge refclk);
  endtask

  // Drive this cycle's inputs and queue the expected post-edge outputs.
  task automatic apply(input bit r, input bit rr, input bit lk);
    rst = r; restart_req = rr; pll_locked = lk;
    model_step(r, rr, lk);
    sb.push_back(model_out());
  endtask

  // Monitor: one comparison of the full output vector after every edge.
  initial begin
    obs_t exp_o, act_o;
    forever begin
      @(posedge refclk);
      #1;
      if (sb.size() > 0) begin
        exp_o = sb.pop_front();
        act_o = {state, pll_rst, core_reset, ready, fail, retry_cnt};
        check("outputs{st,pr,cr,rd,fl,rc}", int'(act_o), int'(exp_o));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  fall_k, lock_k, ready_k, hi, pulses, max_rc, g, st_seen, pr_after;
    bit  lk, prev_pr, done, glitched, saw_wait;
    int  hold;
    bit  r, rr;

    // ---------------- Test 1: clean bring-up ----------------
    sample(); apply(1, 0, 0);
    sample(); apply(1, 0, 0);
    fall_k = -1; lock_k = -1; ready_k = -1; hi = 0; done = 0;
    for (int k = 0; k < 60; k++) begin
      sample();
      if (k == 0)
        check("reset_state", int'({state, pll_rst, core_reset, ready, fail, retry_cnt}),
              int'(obs_t'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0})));
      if (pll_rst && fall_k < 0) hi++;
      if (!pll_rst && fall_k < 0) fall_k = k;
      if (ready) begin
        ready_k = k; done = 1;
        check("t1_core_reset_low", int'(core_reset), 0);
        check("t1_retry_zero", int'(retry_cnt), 0);
      end
      lk = (fall_k >= 0) && (k >= fall_k + 3);
      if (lk && lock_k < 0) lock_k = k;
      apply(0, 0, lk);
      if (done) break;
    end
    check("t1_pll_rst_cycles", hi, RP);
    check("t1_ready_latency", ready_k - lock_k, ST + 1 + SYNC_LAT);

    // ---------------- Test 3: lock glitch in STABLE ----------------
    sample(); apply(1, 0, 1);
    st_seen = 0; glitched = 0; g = -1; pr_after = 0; ready_k = -1; done = 0;
    saw_wait = 0;
    for (int k = 0; k < 80; k++) begin
      sample();
      if (glitched && pll_rst) pr_after++;
      if (glitched && state == 3'd1) saw_wait = 1;
      if (ready) begin ready_k = k; done = 1; end
      lk = 1'b1;
      if (state == 3'd2 && !glitched) begin
        if (st_seen == 5) begin lk = 1'b0; glitched = 1; g = k; end
        st_seen++;
      end
      apply(0, 0, lk);
      if (done) break;
    end
    check("t3_glitch_issued", int'(glitched), 1);
    check("t3_returned_to_wait", int'(saw_wait), 1);
    check("t3_no_pll_rst", pr_after, 0);
    check("t3_retry_unchanged", int'(retry_cnt), 0);
    check("t3_ready_after_glitch", ready_k - g, ST + 2 + SYNC_LAT);

    // ---------------- Test 4: lock loss in RUN ----------------
    sample(); apply(0, 0, 0);
    hi = 0; done = 0;
    for (int j = 1; j < 60; j++) begin
      sample();
      if (j == SYNC_LAT + 1) begin
        check("t4_ready_drop", int'(ready), 0);
        check("t4_core_reset_high", int'(core_reset), 1);
        check("t4_pll_rst_high", int'(pll_rst), 1);
      end
      if (pll_rst) hi++;
      if (ready && j > SYNC_LAT + 1) done = 1;
      apply(0, 0, 1);
      if (done) break;
    end
    check("t4_pll_rst_cycles", hi, RP);
    check("t4_relock_ready", int'(done), 1);

    // ---------------- Test 2: never lock ----------------
    sample(); apply(1, 0, 0);
    hi = 0; pulses = 0; prev_pr = 0; max_rc = 0; fall_k = -1;
    for (int k = 0; k < 3 * (RP + LT) + 8; k++) begin
      sample();
      if (pll_rst) hi++;
      if (pll_rst && !prev_pr) pulses++;
      prev_pr = pll_rst;
      if (int'(retry_cnt) > max_rc) max_rc = int'(retry_cnt);
      if (fail && fall_k < 0) fall_k = k;
      apply(0, 0, 0);
    end
    sample();
    check("t2_pulses", pulses, MR + 1);
    check("t2_pll_rst_cycles", hi, (MR + 1) * RP);
    check("t2_max_retry", max_rc, MR);
    check("t2_fail_time", fall_k, (MR + 1) * (RP + LT));
    check("t2_state_fail", int'(state), P_FAIL);
    check("t2_pll_rst_low", int'(pll_rst), 0);
    apply(0, 0, 0);

    // ---------------- Test 5: restart from FAIL, rst+restart ----------------
    sample(); apply(0, 1, 0);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (k == 0) begin
        check("t5_fail_cleared", int'(fail), 0);
        check("t5_retry_cleared", int'(retry_cnt), 0);
      end
      if (pll_rst) hi++;
      apply(0, 0, 0);
    end
    check("t5_restart_pulse", hi, RP);
    sample(); apply(1, 1, 0);
    sample();
    check("t5_rst_wins_state", int'(state), P_RST);
    check("t5_rst_wins_retry", int'(retry_cnt), 0);
    apply(0, 0, 0);

    // ---------------- Randomized traffic ----------------
    hold = 0; lk = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      sample();
      if (hold == 0) begin
        lk = ~lk;
        hold = lk ? int'($urandom_range(5, 40)) : int'($urandom_range(1, 70));
      end
      hold--;
      r  = ($urandom_range(0, 299) == 0);
      rr = ($urandom_range(0, 49) == 0);
      apply(r, rr, lk);
    end

    repeat (3) @(posedge refclk);
    #2;
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
